// File: rtl/carregador_de_programa_pkg.sv
// Shared types and widths for the program loader.
// CARREGADOR_CHECKSUM_EN adds the CHECKSUM state to the state enum.
package carregador_de_programa_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CONT_HI   = 3'd1,
        CONT_LO   = 3'd2,
        DADOS     = 3'd3,
`ifdef CARREGADOR_CHECKSUM_EN
        CHECKSUM  = 3'd4,
`endif
        CONCLUIDO = 3'd5,
        ERRO      = 3'd6
    } estado_t;

    // States in which a byte can be accepted and the CPU must be held.
    function automatic logic em_sessao(input estado_t e);
        return (e == CONT_HI) || (e == CONT_LO) || (e == DADOS)
`ifdef CARREGADOR_CHECKSUM_EN
            || (e == CHECKSUM)
`endif
            ;
    endfunction

endpackage

// File: rtl/carregador_de_programa_montador.sv
// Byte-to-word assembler: 3-byte shift register plus a 2-bit byte counter.
// palavra_o already includes the byte presented this cycle.
module montador_de_palavra
    import carregador_de_programa_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                limpar_i,
    input  logic                byte_en_i,
    input  logic [BYTE_W-1:0]   byte_i,
    output logic [WORD_W-1:0]   palavra_o,
    output logic                ultimo_byte_o
);

    logic [WORD_W-BYTE_W-1:0] sr_q;
    logic [1:0]               cnt_q;

    always_ff @(posedge clock) begin
        if (reset || limpar_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (byte_en_i) begin
            sr_q  <= {sr_q[WORD_W-2*BYTE_W-1:0], byte_i};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign palavra_o     = {sr_q, byte_i};
    assign ultimo_byte_o = (cnt_q == 2'd3);

endmodule

// File: rtl/carregador_de_programa.sv
// Program loader: receives a counted byte stream and writes 32-bit words to instruction memory.
// Optional CARREGADOR_CHECKSUM_EN appends an XOR checksum byte to the stream.
module carregador_de_programa
    import carregador_de_programa_pkg::*;
#(
    parameter int MEM_SIZE   = 72,
    parameter int ADDR_WIDTH = 26
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [7:0]            byte_dado,
    input  logic                  byte_valido,
    output logic                  byte_pronto,
    output logic                  escrita,
    output logic [ADDR_WIDTH-1:0] endereco,
    output logic [31:0]           instrucao,
    output logic                  carregando,
    output logic                  concluido,
    output logic                  erro
);

    localparam logic [COUNT_W-1:0] LIMITE = COUNT_W'(MEM_SIZE);
`ifdef CARREGADOR_CHECKSUM_EN
    localparam estado_t FIM = CHECKSUM;
`else
    localparam estado_t FIM = CONCLUIDO;
`endif

    estado_t               estado_q, estado_d;
    logic [COUNT_W-1:0]    contagem_q, contagem_d;
    logic [COUNT_W-1:0]    indice_q, indice_d;
    logic [ADDR_WIDTH-1:0] endereco_q, endereco_d;
    logic [WORD_W-1:0]     instrucao_q, instrucao_d;
    logic                  escrita_q, escrita_d;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [BYTE_W-1:0]     xor_q, xor_d;
`endif

    logic                  xfer;
    logic                  limpar;
    logic                  byte_palavra;
    logic [WORD_W-1:0]     palavra;
    logic                  ultimo_byte;
    logic [COUNT_W-1:0]    n_recebido;
    logic [COUNT_W-1:0]    indice_prox;

    assign byte_pronto = em_sessao(estado_q);
    assign carregando  = em_sessao(estado_q);
    assign concluido   = (estado_q == CONCLUIDO);
    assign erro        = (estado_q == ERRO);
    assign escrita     = escrita_q;
    assign endereco    = endereco_q;
    assign instrucao   = instrucao_q;

    assign xfer        = byte_valido && byte_pronto;
    assign n_recebido  = {contagem_q[COUNT_W-1:BYTE_W], byte_dado};
    assign indice_prox = indice_q + 1'b1;

    montador_de_palavra u_montador (
        .clock        (clock),
        .reset        (reset),
        .limpar_i     (limpar),
        .byte_en_i    (byte_palavra),
        .byte_i       (byte_dado),
        .palavra_o    (palavra),
        .ultimo_byte_o(ultimo_byte)
    );

    always_comb begin
        estado_d     = estado_q;
        contagem_d   = contagem_q;
        indice_d     = indice_q;
        endereco_d   = endereco_q;
        instrucao_d  = instrucao_q;
        escrita_d    = 1'b0;
        limpar       = 1'b0;
        byte_palavra = 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
        xor_d        = xfer ? (xor_q ^ byte_dado) : xor_q;
`endif
        case (estado_q)
            OCIOSO, CONCLUIDO, ERRO: begin
                if (iniciar) begin
                    estado_d   = CONT_HI;
                    indice_d   = '0;
                    contagem_d = '0;
                    limpar     = 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            CONT_HI: begin
                if (xfer) begin
                    contagem_d = {byte_dado, contagem_q[BYTE_W-1:0]};
                    estado_d   = CONT_LO;
                end
            end
            CONT_LO: begin
                if (xfer) begin
                    contagem_d = n_recebido;
                    indice_d   = '0;
                    if (n_recebido == '0)        estado_d = FIM;
                    else if (n_recebido > LIMITE) estado_d = ERRO;
                    else                          estado_d = DADOS;
                end
            end
            DADOS: begin
                if (xfer) begin
                    byte_palavra = 1'b1;
                    if (ultimo_byte) begin
                        escrita_d   = 1'b1;
                        instrucao_d = palavra;
                        endereco_d  = ADDR_WIDTH'(indice_q);
                        indice_d    = indice_prox;
                        // Leave DADOS on the same edge that raises the final escrita.
                        if (indice_prox == contagem_q) estado_d = FIM;
                    end
                end
            end
`ifdef CARREGADOR_CHECKSUM_EN
            CHECKSUM: begin
                if (xfer) estado_d = (byte_dado == xor_q) ? CONCLUIDO : ERRO;
            end
`endif
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            contagem_q  <= '0;
            indice_q    <= '0;
            endereco_q  <= '0;
            instrucao_q <= '0;
            escrita_q   <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            estado_q    <= estado_d;
            contagem_q  <= contagem_d;
            indice_q    <= indice_d;
            endereco_q  <= endereco_d;
            instrucao_q <= instrucao_d;
            escrita_q   <= escrita_d;
`ifdef CARREGADOR_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_carregador_de_programa.sv
// Directed bench for carregador_de_programa with a write scoreboard.
// Honours CARREGADOR_CHECKSUM_EN by appending checksum bytes to the streams.
module tb_carregador_de_programa;

    localparam int AW = 26;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iniciar = 1'b0;
    logic [7:0]    byte_dado = '0;
    logic          byte_valido = 1'b0;
    logic          byte_pronto;
    logic          escrita;
    logic [AW-1:0] endereco;
    logic [31:0]   instrucao;
    logic          carregando;
    logic          concluido;
    logic          erro;

    int checks = 0;
    int errors = 0;

    logic [57:0] exp_q[$];   // {addr, data}
    logic [7:0]  stm[$];

    always #5 clock = ~clock;

    carregador_de_programa #(.MEM_SIZE(72), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .byte_dado  (byte_dado),
        .byte_valido(byte_valido),
        .byte_pronto(byte_pronto),
        .escrita    (escrita),
        .endereco   (endereco),
        .instrucao  (instrucao),
        .carregando (carregando),
        .concluido  (concluido),
        .erro       (erro)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every escrita must match the next expected write.
    always @(negedge clock) begin
        if (escrita) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {6'd0, endereco, instrucao}, 64'hDEAD);
            end else begin
                logic [57:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(endereco), 64'(e[57:32]));
                chk("write_data", 64'(instrucao), 64'(e[31:0]));
            end
        end
        if (concluido) chk("concluido_early", 64'(exp_q.size()), 64'd0);
    end

    task automatic push_w(input logic [25:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic add_cks();
`ifdef CARREGADOR_CHECKSUM_EN
        logic [7:0] x;
        x = '0;
        foreach (stm[i]) x ^= stm[i];
        stm.push_back(x);
`endif
    endtask

    task automatic start();
        @(negedge clock);
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
    endtask

    // One byte per call; a gap inserts an idle cycle with iniciar raised, which must be ignored.
    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) begin
            @(negedge clock);
            byte_valido = 1'b0;
            byte_dado   = 8'($urandom);
            iniciar     = 1'b1;
        end
        @(negedge clock);
        iniciar     = 1'b0;
        byte_valido = 1'b1;
        byte_dado   = b;
        chk("byte_pronto", 64'(byte_pronto), 64'd1);
        @(posedge clock);
    endtask

    task automatic play(input bit gaps);
        foreach (stm[i]) send(stm[i], gaps && (i != 0));
        @(negedge clock);
        byte_valido = 1'b0;
    endtask

    task automatic fin(input string tag, input logic c, input logic e);
        @(negedge clock);
        @(negedge clock);
        chk({tag, "_concluido"}, 64'(concluido), 64'(c));
        chk({tag, "_erro"}, 64'(erro), 64'(e));
        chk({tag, "_carregando"}, 64'(carregando), 64'd0);
        chk({tag, "_pronto"}, 64'(byte_pronto), 64'd0);
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_outs"}, {56'd0, byte_pronto, escrita, carregando, concluido, erro, 3'd0}, 64'd0);
        chk({tag, "_addr"}, 64'(endereco), 64'd0);
        chk({tag, "_instr"}, 64'(instrucao), 64'd0);
    endtask

    task automatic load_two(input bit gaps);
        stm = '{8'h00, 8'h02, 8'h74, 8'h00, 8'h00, 8'h28, 8'h08, 8'h63, 8'h00, 8'h07};
        add_cks();
        start();
        chk("carregando_start", 64'(carregando), 64'd1);
        push_w(26'd0, 32'h7400_0028);
        push_w(26'd1, 32'h0863_0007);
        play(gaps);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        outputs_zero("reset");
        reset = 1'b0;

        // Two-word load, back to back.
        load_two(1'b0);
        fin("two_words", 1'b1, 1'b0);

        // Count over the memory size.
        stm = '{8'h00, 8'h49};
        start();
        play(1'b0);
        fin("oversize", 1'b0, 1'b1);

        // Empty program.
        stm = '{8'h00, 8'h00};
        add_cks();
        start();
        play(1'b0);
        fin("empty", 1'b1, 1'b0);

        // Same two-word load with byte_valido toggling.
        load_two(1'b1);
        fin("toggled", 1'b1, 1'b0);

        // Reset after the 6th byte: word 0 is already committed, nothing after.
        stm = '{8'h00, 8'h02, 8'h74, 8'h00, 8'h00, 8'h28};
        start();
        push_w(26'd0, 32'h7400_0028);
        foreach (stm[i]) send(stm[i], 1'b0);
        @(negedge clock);
        byte_valido = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        outputs_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        outputs_zero("after_reset");
        chk("after_reset_pending", 64'(exp_q.size()), 64'd0);
        load_two(1'b0);
        fin("reload", 1'b1, 1'b0);

`ifdef CARREGADOR_CHECKSUM_EN
        stm = '{8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFD};
        start();
        push_w(26'd0, 32'hFC00_0000);
        play(1'b0);
        fin("cks_ok", 1'b1, 1'b0);

        stm = '{8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFE};
        start();
        push_w(26'd0, 32'hFC00_0000);
        play(1'b0);
        fin("cks_bad", 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/carregador_de_programa.md
CARREGADOR_DE_PROGRAMA -- requirements
Module: carregador_de_programa

Interface
REQ-001 Parameter MEM_SIZE, default 72: instruction-memory depth in words; upper bound on the accepted word count.
REQ-002 Parameter ADDR_WIDTH, default 26: width of the write address; matches the PC width.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 iniciar  in  1  one-cycle start request for a load session.
REQ-006 byte_dado  in  8  incoming program byte.
REQ-007 byte_valido  in  1  byte_dado is valid this cycle.
REQ-008 byte_pronto  out  1  block accepts a byte this cycle; a transfer occurs when byte_valido and byte_pronto are both 1.
REQ-009 escrita  out  1  one-cycle write strobe to the instruction memory.
REQ-010 endereco  out  ADDR_WIDTH  word address for escrita.
REQ-011 instrucao  out  32  word to be written.
REQ-012 carregando  out  1  session in progress; CPU held while 1.
REQ-013 concluido  out  1  last session completed successfully.
REQ-014 erro  out  1  last session aborted.

Function
REQ-015 States SHALL be OCIOSO, CONT_HI, CONT_LO, DADOS, CHECKSUM, CONCLUIDO and ERRO.
REQ-016 OCIOSO->CONT_HI SHALL occur on iniciar; iniciar SHALL be ignored in CONT_HI, CONT_LO, DADOS and CHECKSUM.
REQ-017 byte_pronto SHALL be 1 only in CONT_HI, CONT_LO, DADOS and CHECKSUM; carregando SHALL be 1 in exactly those states.
REQ-018 Stream format SHALL be a 16-bit word count N (big-endian: CONT_HI byte, then CONT_LO byte), followed by N words of 4 bytes each, MSB first.
REQ-019 On the CONT_LO transfer: N=0 -> CONCLUIDO (or CHECKSUM when checksum is enabled); N>MEM_SIZE -> ERRO; otherwise -> DADOS with word index 0.
REQ-020 On the 4th byte transfer of a word, instrucao SHALL load the assembled word and endereco the word index; escrita SHALL be 1 exactly in the following cycle.
REQ-021 byte_pronto SHALL stay 1 during the escrita cycle, so back-to-back bytes sustain 1 byte/cycle with no loss.
REQ-022 The word index SHALL increment after each word; after word N-1 the FSM SHALL leave DADOS in the same cycle escrita is asserted, and concluido SHALL never rise before the final escrita.
REQ-023 From CONCLUIDO or ERRO, iniciar SHALL start a new session: flags cleared, index 0.
REQ-024 Cycles with byte_valido=0 SHALL stall the FSM with no state change.

Reset
REQ-025 On reset the FSM SHALL go to OCIOSO, and byte_pronto, escrita, carregando, concluido and erro SHALL be 0, and endereco and instrucao SHALL be 0.
REQ-026 Reset mid-session SHALL abort the session with no further escrita; words already written are not revoked.

Configuration
REQ-027 With CARREGADOR_CHECKSUM_EN defined, the block SHALL keep a running XOR of all count and data bytes; after the last word (or after N=0) it SHALL accept one CHECKSUM byte; match -> CONCLUIDO, mismatch -> ERRO.
REQ-028 Without CARREGADOR_CHECKSUM_EN, the CHECKSUM state and the XOR register SHALL be absent, and the last word SHALL go directly to CONCLUIDO.

Structure
REQ-029 The shared package SHALL hold the state enum, BYTE_W=8, WORD_W=32 and COUNT_W=16.
REQ-030 Byte-to-word assembly (shift register plus 2-bit byte counter) SHALL be the sub-module montador_de_palavra.

Verification
REQ-031 iniciar, then bytes 00 02 74 00 00 28 08 63 00 07 -> escrita at addr 0 with data 0x74000028, then at addr 1 with data 0x08630007; concluido=1, carregando=0.
REQ-032 Count 00 49 (73 > 72) -> ERRO after the 2nd byte, no escrita, erro=1.
REQ-033 Count 00 00 -> CONCLUIDO with zero escrita; with CARREGADOR_CHECKSUM_EN, checksum byte 00 is also required.
REQ-034 Same stream as REQ-031 with byte_valido toggling every other cycle -> identical writes, no duplicated or dropped bytes.
REQ-035 Reset asserted after the 6th byte -> OCIOSO, all outputs 0, no further escrita; a fresh session then loads correctly.
REQ-036 With CARREGADOR_CHECKSUM_EN: stream 00 01 FC 00 00 00 plus checksum FD -> CONCLUIDO; the same stream with checksum FE -> erro=1 after one escrita.
